// File: rtl/rx_frame_meter.sv
// XGMII RX measurement stage: parses generator test frames, measures one-way latency and
// accumulates per-second frame/byte counts for the PCI user registers.
module rx_frame_meter #(
  parameter logic [31:0] MAGIC_CODE = 32'h5a5a_a5a5
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic [63:0] xgmii_rxd,
  input  logic [7:0]  xgmii_rxc,
  input  logic        sec_oneshot,
  input  logic [31:0] global_counter,
  output logic [31:0] rx_pps,
  output logic [31:0] rx_throughput,
  output logic [23:0] rx_latency,
  output logic [31:0] rx_ipv4_ip
);

  typedef enum logic [1:0] {StIdle, StRecv, StDiscard} state_e;

  state_e      state_q, state_d;
  logic [3:0]  widx_q, widx_d;
  logic [31:0] len_q, len_d;
  logic        hdr_ok_q, hdr_ok_d;
  logic [31:0] dst_q, dst_d;
  logic [31:0] ts_q, ts_d;
  logic [31:0] arr_q, arr_d;

  logic        commit_q, commit_d;
  logic        commit_test_q, commit_test_d;
  logic [31:0] commit_len_q, commit_len_d;
  logic [31:0] commit_ip_q, commit_ip_d;
  logic [23:0] commit_lat_q, commit_lat_d;

  logic [31:0] pps_cnt_q, byte_cnt_q;
  logic [31:0] pps_next, bytes_next;
  logic [32:0] pps_sum, byte_sum;
  logic [31:0] rx_pps_q, rx_throughput_q, rx_ipv4_ip_q;
  logic [23:0] rx_latency_q;

  logic        sof;
  logic        has_ctrl;
  logic [2:0]  ctrl_lane;
  logic [7:0]  ctrl_byte;
  logic [31:0] diff;

  assign sof      = (xgmii_rxc == 8'h01) && (xgmii_rxd[7:0] == 8'hfb);
  assign has_ctrl = |xgmii_rxc;
  assign diff     = arr_q - ts_q;

  // Lowest control lane decides how the frame ends.
  always_comb begin
    ctrl_lane = 3'd0;
    ctrl_byte = 8'h00;
    for (int k = 7; k >= 0; k--) begin
      if (xgmii_rxc[k]) begin
        ctrl_lane = 3'(k);
        ctrl_byte = xgmii_rxd[8*k +: 8];
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    widx_d        = widx_q;
    len_d         = len_q;
    hdr_ok_d      = hdr_ok_q;
    dst_d         = dst_q;
    ts_d          = ts_q;
    arr_d         = arr_q;
    commit_d      = 1'b0;
    commit_test_d = 1'b0;
    commit_len_d  = len_q + 32'(ctrl_lane);
    commit_ip_d   = dst_q;
    commit_lat_d  = (diff[31:24] != 8'h00) ? 24'hffffff : diff[23:0];

    if (sof) begin
      state_d  = StRecv;
      widx_d   = 4'd1;
      len_d    = 32'd0;
      hdr_ok_d = 1'b1;
    end else begin
      case (state_q)
        StRecv: begin
          case (widx_q)
            4'd2: begin
              if (xgmii_rxd[47:32] != 16'h0008 || xgmii_rxd[55:48] != 8'h45) hdr_ok_d = 1'b0;
            end
            4'd3: if (xgmii_rxd[63:56] != 8'h11) hdr_ok_d = 1'b0;
            4'd4: dst_d[31:16] = {xgmii_rxd[55:48], xgmii_rxd[63:56]};
            4'd5: dst_d[15:0] = {xgmii_rxd[7:0], xgmii_rxd[15:8]};
            4'd6: begin
              if ({xgmii_rxd[23:16], xgmii_rxd[31:24], xgmii_rxd[39:32], xgmii_rxd[47:40]}
                  != MAGIC_CODE) hdr_ok_d = 1'b0;
              ts_d[31:16] = {xgmii_rxd[55:48], xgmii_rxd[63:56]};
              arr_d       = global_counter;
            end
            4'd7: ts_d[15:0] = {xgmii_rxd[7:0], xgmii_rxd[15:8]};
            default: ;
          endcase

          if (has_ctrl) begin
            if (ctrl_byte == 8'hfd) begin
              state_d       = StIdle;
              commit_d      = 1'b1;
              // Index 8 means words 1..7 arrived complete, so all header fields are valid.
              commit_test_d = hdr_ok_q && (widx_q == 4'd8);
            end else begin
              state_d = StDiscard;
            end
          end else begin
            len_d  = len_q + 32'd8;
            widx_d = (widx_q == 4'd8) ? 4'd8 : widx_q + 4'd1;
          end
        end
        StDiscard: if (xgmii_rxc == 8'hff) state_d = StIdle;
        default: ;
      endcase
    end
  end

  assign pps_sum  = {1'b0, pps_cnt_q} + 33'd1;
  assign byte_sum = {1'b0, byte_cnt_q} + {1'b0, commit_len_q};

  always_comb begin
    pps_next   = pps_cnt_q;
    bytes_next = byte_cnt_q;
    if (commit_q) begin
      pps_next   = pps_sum[32] ? 32'hffff_ffff : pps_sum[31:0];
      bytes_next = byte_sum[32] ? 32'hffff_ffff : byte_sum[31:0];
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q         <= StIdle;
      widx_q          <= 4'd0;
      len_q           <= 32'd0;
      hdr_ok_q        <= 1'b0;
      dst_q           <= 32'd0;
      ts_q            <= 32'd0;
      arr_q           <= 32'd0;
      commit_q        <= 1'b0;
      commit_test_q   <= 1'b0;
      commit_len_q    <= 32'd0;
      commit_ip_q     <= 32'd0;
      commit_lat_q    <= 24'd0;
      pps_cnt_q       <= 32'd0;
      byte_cnt_q      <= 32'd0;
      rx_pps_q        <= 32'd0;
      rx_throughput_q <= 32'd0;
      rx_latency_q    <= 24'd0;
      rx_ipv4_ip_q    <= 32'd0;
    end else begin
      state_q       <= state_d;
      widx_q        <= widx_d;
      len_q         <= len_d;
      hdr_ok_q      <= hdr_ok_d;
      dst_q         <= dst_d;
      ts_q          <= ts_d;
      arr_q         <= arr_d;
      commit_q      <= commit_d;
      commit_test_q <= commit_test_d;
      commit_len_q  <= commit_len_d;
      commit_ip_q   <= commit_ip_d;
      commit_lat_q  <= commit_lat_d;

      // A commit landing on the second boundary belongs to the window being reported.
      if (sec_oneshot) begin
        rx_pps_q        <= pps_next;
        rx_throughput_q <= bytes_next;
        pps_cnt_q       <= 32'd0;
        byte_cnt_q      <= 32'd0;
      end else begin
        pps_cnt_q  <= pps_next;
        byte_cnt_q <= bytes_next;
      end

      if (commit_q && commit_test_q) begin
        rx_latency_q <= commit_lat_q;
        rx_ipv4_ip_q <= commit_ip_q;
      end
    end
  end

  assign rx_pps        = rx_pps_q;
  assign rx_throughput = rx_throughput_q;
  assign rx_latency    = rx_latency_q;
  assign rx_ipv4_ip    = rx_ipv4_ip_q;

endmodule

// File: tb/tb_rx_frame_meter.sv
// Randomized self-checking bench for rx_frame_meter against a frame-level reference model.
module tb_rx_frame_meter;

  localparam logic [31:0] Magic  = 32'h5a5a_a5a5;
  localparam logic [63:0] IdleD  = {8{8'h07}};
  localparam logic [63:0] SofD   = 64'hd555_5555_5555_55fb;

  typedef struct packed {
    logic [15:0] n;
    logic [31:0] dst;
    logic [31:0] ts;
    logic [31:0] arr;
    logic [31:0] magic;
    logic [7:0]  proto;
    logic        eth_ok;
  } frame_t;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic [63:0] xgmii_rxd;
  logic [7:0]  xgmii_rxc;
  logic        sec_oneshot;
  logic [31:0] global_counter;
  logic [31:0] rx_pps;
  logic [31:0] rx_throughput;
  logic [23:0] rx_latency;
  logic [31:0] rx_ipv4_ip;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: open window, last reported window, last test-frame results.
  logic [31:0] win_pps, win_bytes, rep_pps, rep_bytes, exp_ip;
  logic [23:0] exp_lat;

  rx_frame_meter dut (
    .sys_clk        (sys_clk),
    .sys_rst        (sys_rst),
    .xgmii_rxd      (xgmii_rxd),
    .xgmii_rxc      (xgmii_rxc),
    .sec_oneshot    (sec_oneshot),
    .global_counter (global_counter),
    .rx_pps         (rx_pps),
    .rx_throughput  (rx_throughput),
    .rx_latency     (rx_latency),
    .rx_ipv4_ip     (rx_ipv4_ip)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic put_word(input logic [63:0] d, input logic [7:0] c, input logic [31:0] gc,
                          input logic sec, input logic rst);
    xgmii_rxd      = d;
    xgmii_rxc      = c;
    global_counter = gc;
    sec_oneshot    = sec;
    sys_rst        = rst;
    @(posedge sys_clk);
    #1;
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) put_word(IdleD, 8'hff, $urandom, 1'b0, 1'b0);
  endtask

  function automatic frame_t mk(input int n, input logic [31:0] dst, input logic [31:0] ts,
                                input logic [31:0] arr);
    frame_t f;
    f.n      = 16'(n);
    f.dst    = dst;
    f.ts     = ts;
    f.arr    = arr;
    f.magic  = Magic;
    f.proto  = 8'h11;
    f.eth_ok = 1'b1;
    return f;
  endfunction

  // mode: 0 normal, 1 control 8'hfe at byte err_pos, 2 no terminate, 3 reset during word 4
  task automatic send_frame(input frame_t f, input int mode, input int err_pos, input int ipg);
    logic [7:0]  b [2048];
    logic [63:0] d;
    logic [7:0]  c;
    int          n, w, pos;
    bit          done;
    n = int'(f.n);
    for (int i = 0; i < 2048; i++) b[i] = 8'($urandom);
    b[12] = f.eth_ok ? 8'h08 : 8'h86;
    b[13] = 8'h00;
    b[14] = 8'h45;
    b[23] = f.proto;
    {b[30], b[31], b[32], b[33]} = f.dst;
    {b[42], b[43], b[44], b[45]} = f.magic;
    {b[46], b[47], b[48], b[49]} = f.ts;
    put_word(SofD, 8'h01, $urandom, 1'b0, 1'b0);
    done = 1'b0;
    w    = 1;
    while (!done) begin
      d = '0;
      c = '0;
      for (int l = 0; l < 8; l++) begin
        pos = 8 * (w - 1) + l;
        if (mode == 1 && pos >= err_pos) begin
          c[l]       = 1'b1;
          d[8*l +: 8] = (pos == err_pos) ? 8'hfe : 8'h07;
        end else if (pos < n) begin
          d[8*l +: 8] = b[pos];
        end else begin
          c[l]       = 1'b1;
          d[8*l +: 8] = (pos == n) ? 8'hfd : 8'h07;
        end
      end
      if (mode == 2 && c != 8'h00) begin
        done = 1'b1;
      end else begin
        put_word(d, c, (w == 6) ? f.arr : $urandom, 1'b0, (mode == 3 && w == 4));
        if (c != 8'h00) done = 1'b1;
      end
      w++;
    end
    idle(ipg);
  endtask

  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[32] ? 32'hffff_ffff : s[31:0];
  endfunction

  // Account a cleanly terminated frame in the open window.
  task automatic model_good(input frame_t f);
    logic [31:0] diff;
    win_pps   = sat_add(win_pps, 32'd1);
    win_bytes = sat_add(win_bytes, 32'(f.n));
    if (f.n >= 16'd56 && f.eth_ok && f.proto == 8'h11 && f.magic == Magic) begin
      diff    = f.arr - f.ts;
      exp_lat = (diff > 32'h00ff_ffff) ? 24'hffffff : diff[23:0];
      exp_ip  = f.dst;
    end
  endtask

  task automatic pulse_sec(input string tag);
    put_word(IdleD, 8'hff, $urandom, 1'b1, 1'b0);
    rep_pps   = win_pps;
    rep_bytes = win_bytes;
    win_pps   = 32'd0;
    win_bytes = 32'd0;
    idle(2);
    check_eq({tag, "_pps"}, rx_pps, rep_pps);
    check_eq({tag, "_thr"}, rx_throughput, rep_bytes);
    check_eq({tag, "_lat"}, {8'h00, rx_latency}, {8'h00, exp_lat});
    check_eq({tag, "_ip"}, rx_ipv4_ip, exp_ip);
  endtask

  task automatic check_outputs_zero(input string tag);
    check_eq({tag, "_pps"}, rx_pps, 32'd0);
    check_eq({tag, "_thr"}, rx_throughput, 32'd0);
    check_eq({tag, "_lat"}, {8'h00, rx_latency}, 32'd0);
    check_eq({tag, "_ip"}, rx_ipv4_ip, 32'd0);
  endtask

  initial begin
    frame_t f;
    int     mode, ipg;
    logic [31:0] ts;
    win_pps = 0; win_bytes = 0; rep_pps = 0; rep_bytes = 0; exp_ip = 0; exp_lat = 0;
    xgmii_rxd = IdleD; xgmii_rxc = 8'hff; sec_oneshot = 1'b0; global_counter = 0;
    sys_rst = 1'b1;
    for (int i = 0; i < 4; i++) put_word(IdleD, 8'hff, $urandom, 1'b0, 1'b1);
    idle(2);
    check_outputs_zero("reset");

    // 64-byte test frame
    f = mk(64, 32'h0a00_1569, 32'h0000_1000, 32'h0000_1234);
    send_frame(f, 0, 0, 2);
    model_good(f);
    check_eq("tp1_lat_const", {8'h00, rx_latency}, 32'h0000_0234);
    check_eq("tp1_ip_const", rx_ipv4_ip, 32'h0a00_1569);
    pulse_sec("tp1");
    check_eq("tp1_pps_const", rx_pps, 32'd1);

    // 1000 back-to-back 66-byte frames, last one with a wrong magic
    for (int i = 0; i < 1000; i++) begin
      ts = $urandom;
      f  = mk(66, $urandom, ts, ts + $urandom_range(0, 50000));
      if (i == 999) f.magic = 32'h0;
      send_frame(f, 0, 0, 0);
      model_good(f);
    end
    pulse_sec("b2b");
    check_eq("b2b_pps_const", rx_pps, 32'd1000);
    check_eq("b2b_thr_const", rx_throughput, 32'd66000);

    // 8'hfe in lane 3 of word 5, then a normal frame
    send_frame(mk(64, 32'hdead_beef, 32'h10, 32'h20), 1, 35, 2);
    f = mk(64, 32'h0102_0304, 32'h100, 32'h180);
    send_frame(f, 0, 0, 2);
    model_good(f);
    pulse_sec("err");

    // Restart on SOF mid-frame; second boundary coincides with the commit
    send_frame(mk(64, 32'hbad0_bad0, 32'h0, 32'h5), 2, 0, 0);
    f = mk(40, 32'h0, 32'h0, 32'h0);
    send_frame(f, 0, 0, 0);
    model_good(f);
    pulse_sec("abort");
    pulse_sec("empty");

    // Latency saturation and timestamp wrap
    f = mk(64, 32'hc0a8_0001, 32'h00ff_ffff, 32'h0200_0000);
    send_frame(f, 0, 0, 2);
    model_good(f);
    check_eq("lat_sat", {8'h00, rx_latency}, 32'h00ff_ffff);
    f = mk(64, 32'hc0a8_0002, 32'hffff_fff0, 32'h0000_0010);
    send_frame(f, 0, 0, 2);
    model_good(f);
    check_eq("lat_wrap", {8'h00, rx_latency}, 32'h0000_0020);
    pulse_sec("lat");

    // Random mix of lengths, header variants, errors and aborts
    for (int i = 0; i < 300; i++) begin
      ts = $urandom;
      f  = mk($urandom_range(20, 150), $urandom, ts, ts + $urandom_range(0, 32'h0200_0000));
      if ($urandom_range(0, 3) == 0) f.magic = $urandom;
      if ($urandom_range(0, 3) == 0) f.proto = 8'h06;
      if ($urandom_range(0, 7) == 0) f.eth_ok = 1'b0;
      mode = $urandom_range(0, 9);
      ipg  = $urandom_range(0, 2);
      if (mode == 0) send_frame(f, 1, $urandom_range(1, int'(f.n) - 1), ipg);
      else if (mode == 1) send_frame(f, 2, 0, ipg);
      else begin
        send_frame(f, 0, 0, ipg);
        model_good(f);
      end
      if (i % 20 == 19) pulse_sec("rand");
    end

    // Reset during word 4 of a frame
    send_frame(mk(64, 32'h0909_0909, 32'h0, 32'h7), 3, 0, 2);
    win_pps = 0; win_bytes = 0; rep_pps = 0; rep_bytes = 0; exp_ip = 0; exp_lat = 0;
    check_outputs_zero("midrst");
    pulse_sec("postrst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
